calc_display_bank: RTL and testbench
====================================

CALC_DISPLAY_BANK -- requirements
Module: calc_display_bank

Interface
REQ-001 Parameter N_DIGITS, default 8, number of digit positions; legal range 2..16.
REQ-002 Derived constant POS_W = $clog2(N_DIGITS), the position field width.
REQ-003 Port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, command present.
REQ-006 Port cmd_ready, output, 1, block can accept a command this cycle.
REQ-007 Port cmd_op, input, 2, opcode: WRITE=0, SHIFT=1, BKSP=2, CLEAR=3.
REQ-008 Port dig, input, 4, BCD digit for WRITE/SHIFT.
REQ-009 Port pos, input, POS_W, target position for WRITE; 0 is the least significant digit.
REQ-010 Port displays, output, N_DIGITS x 7, segments g..a per digit (bit0=a), active-high.
REQ-011 Port count, output, POS_W+1, number of entered digits, 0..N_DIGITS.
REQ-012 Port ovf, output, 1, sticky overflow flag.
REQ-013 Port err, output, 1, one-cycle pulse on a rejected command.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; the digit registers update on that edge, and displays reflect the change combinationally after it.
REQ-015 The FSM SHALL have states IDLE (cmd_ready=1) and CLEAR (cmd_ready=0).
REQ-016 WRITE SHALL set data[pos]<=dig and count<=max(count, pos+1).
REQ-017 SHIFT SHALL set data[i]<=data[i-1] for i>=1, data[0]<=dig, and count<=min(count+1, N_DIGITS).
REQ-018 A SHIFT accepted while count==N_DIGITS SHALL discard data[N_DIGITS-1] and set ovf, which remains set until CLEAR or reset.
REQ-019 BKSP SHALL set data[i]<=data[i+1], data[N_DIGITS-1]<=0, and decrement count if it is nonzero.
REQ-020 BKSP with count==0 SHALL change no state.
REQ-021 CLEAR SHALL enter CLEAR, zero count and ovf on the accept edge, zero data[k] on the k-th cycle in CLEAR (k=0..N_DIGITS-1), then return to IDLE; occupancy is N_DIGITS cycles.
REQ-022 A WRITE or SHIFT with dig>9, or a WRITE with pos>=N_DIGITS, SHALL be accepted with no state change and SHALL pulse err on the following cycle.
REQ-023 Every valid command SHALL leave err at 0.
REQ-024 cmd_valid while cmd_ready=0 SHALL be ignored; no queuing.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL set: all data=0, count=0, ovf=0, err=0, state=IDLE, cmd_ready=1.
REQ-026 Reset SHALL take priority over a simultaneous command and SHALL abort an in-progress CLEAR.

Configuration
REQ-027 Macro CALC_LZB_EN enables leading-digit blanking.
REQ-028 With CALC_LZB_EN defined, digit i with i>=count and i>0 SHALL output 7'b0000000, and digit 0 SHALL always be decoded.
REQ-029 Without CALC_LZB_EN, every digit SHALL be decoded from its register.

Structure
REQ-030 Package calc_disp_pkg SHALL hold the opcode enum, the segment constant table for 0-9, and SEG_BLANK.
REQ-031 Sub-module seg7_decode (4-bit BCD in, 7-bit segments out) SHALL be instantiated N_DIGITS times via generate.

Verification (N_DIGITS=8)
REQ-032 Reset, then SHIFT 1,2,3 -> data[2:0]=1,2,3 read msd..lsd; count=3; displays[0]=7'b1001111; with LZB, displays[3..7]=0.
REQ-033 Nine SHIFTs of 9 -> count=8, ovf=1, all eight digits show 9; a following BKSP -> count=7, data[7]=0, ovf stays 1.
REQ-034 WRITE dig=5, pos=6 on an empty bank -> data[6]=5, count=7; then WRITE dig=12 -> err pulses for 1 cycle and the bank is unchanged.
REQ-035 CLEAR after REQ-033 -> cmd_ready low for exactly 8 cycles, ovf=0 on the next cycle, all digits 0; a SHIFT issued during CLEAR is ignored.
REQ-036 Reset asserted on the 3rd cycle of CLEAR, concurrently with cmd_valid -> next cycle state IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared opcode, FSM state and seven-segment constants for the calculator display bank.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_SHIFT = 2'd1,
    OP_BKSP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Segment patterns g..a (bit0 = a), entry k lights digit k.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-high seven-segment decoder; codes above 9 render blank.
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/calc_display_bank.sv
// Calculator digit register bank with per-digit seven-segment outputs.
// Define CALC_LZB_EN to blank digits at or above the entered count (digit 0 always shown).
module calc_display_bank
  import calc_disp_pkg::*;
#(
  parameter  int N_DIGITS = 8,
  localparam int POS_W    = $clog2(N_DIGITS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               dig,
  input  logic [POS_W-1:0]         pos,
  output logic [N_DIGITS-1:0][6:0] displays,
  output logic [POS_W:0]           count,
  output logic                     ovf,
  output logic                     err
);

  localparam logic [POS_W:0]   N_CNT    = (POS_W+1)'(N_DIGITS);
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(N_DIGITS - 1);

  logic [N_DIGITS-1:0][3:0] data;
  logic [0:0]               state;
  logic [POS_W-1:0]         clr_idx;
  op_t                      op;
  logic                     accept;
  logic                     bad;
  logic [POS_W:0]           wr_cnt;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_cnt    = {1'b0, pos} + 1'b1;

  always_comb begin
    bad = 1'b0;
    if ((op == OP_WRITE || op == OP_SHIFT) && dig > 4'd9) bad = 1'b1;
    if (op == OP_WRITE && {1'b0, pos} >= N_CNT) bad = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      data    <= '0;
    end else begin
      err <= accept && bad;
      // Clearing walks one digit per cycle; commands are held off meanwhile.
      if (state == ST_CLEAR) begin
        data[clr_idx] <= 4'd0;
        if (clr_idx == LAST_IDX) begin
          state   <= ST_IDLE;
          clr_idx <= '0;
        end else begin
          clr_idx <= clr_idx + 1'b1;
        end
      end else if (accept && !bad) begin
        case (op)
          OP_WRITE: begin
            data[pos] <= dig;
            if (wr_cnt > count) count <= wr_cnt;
          end
          OP_SHIFT: begin
            for (int i = N_DIGITS - 1; i >= 1; i--) data[i] <= data[i-1];
            data[0] <= dig;
            if (count == N_CNT) ovf <= 1'b1;
            else count <= count + 1'b1;
          end
          OP_BKSP: begin
            if (count != '0) begin
              for (int i = 0; i < N_DIGITS - 1; i++) data[i] <= data[i+1];
              data[N_DIGITS-1] <= 4'd0;
              count <= count - 1'b1;
            end
          end
          default: begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            count   <= '0;
            ovf     <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    logic [6:0] seg;
    seg7_decode u_dec (.bcd(data[g]), .seg(seg));
`ifdef CALC_LZB_EN
    if (g == 0) begin : g_lsd
      assign displays[g] = seg;
    end else begin : g_upper
      assign displays[g] = (count > (POS_W+1)'(g)) ? seg : SEG_BLANK;
    end
`else
    assign displays[g] = seg;
`endif
  end

endmodule

// File: tb/tb_calc_display_bank.sv
// Randomised and directed checks of calc_display_bank against an array-based reference model.
module tb_calc_display_bank;

  localparam int N = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [3:0]      dig = 4'd0;
  logic [2:0]      pos = 3'd0;
  logic [N-1:0][6:0] displays;
  logic [3:0]      count;
  logic            ovf;
  logic            err;

  int checks = 0;
  int errors = 0;

  calc_display_bank #(.N_DIGITS(N)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .dig(dig), .pos(pos), .displays(displays),
    .count(count), .ovf(ovf), .err(err)
  );

  always #5 clock = ~clock;

  // Reference model: digit array, count, overflow, pending error, remaining clear cycles.
  int  mdata [N];
  int  mcount;
  bit  movf;
  bit  merr;
  int  mclr_left;
  bit  started = 1'b0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input int i);
`ifdef CALC_LZB_EN
    if (i > 0 && i >= mcount) return 7'b0000000;
`endif
    return seg_of(mdata[i]);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mdata[i] = 0;
      mcount = 0; movf = 0; merr = 0; mclr_left = 0;
      started = 1'b1;
    end else if (started) begin
      bit e;
      e = 0;
      if (mclr_left > 0) begin
        mdata[N - mclr_left] = 0;
        mclr_left--;
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: if (dig > 9 || int'(pos) >= N) e = 1;
                else begin
                  mdata[pos] = dig;
                  if (int'(pos) + 1 > mcount) mcount = int'(pos) + 1;
                end
          2'd1: if (dig > 9) e = 1;
                else begin
                  for (int i = N - 1; i >= 1; i--) mdata[i] = mdata[i-1];
                  mdata[0] = dig;
                  if (mcount == N) movf = 1; else mcount++;
                end
          2'd2: if (mcount > 0) begin
                  for (int i = 0; i < N - 1; i++) mdata[i] = mdata[i+1];
                  mdata[N-1] = 0;
                  mcount--;
                end
          default: begin
            mclr_left = N; mcount = 0; movf = 0;
          end
        endcase
      end
      merr = e;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      logic [N*7-1:0] ed;
      for (int i = 0; i < N; i++) ed[i*7 +: 7] = exp_digit(i);
      check("cmd_ready", 64'(cmd_ready), 64'(mclr_left == 0));
      check("count", 64'(count), 64'(mcount));
      check("ovf", 64'(ovf), 64'(movf));
      check("err", 64'(err), 64'(merr));
      check("displays", 64'(displays), 64'(ed));
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [2:0] p);
    cmd_valid = 1'b1; cmd_op = op; dig = d; pos = p;
    @(posedge clock); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(posedge clock); #2;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int lows;
    @(posedge clock); #2;
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_disp0", 64'(displays[0]), 64'h3F);

    // Three shifts: msd..lsd reads 1,2,3
    send(2'd1, 4'd1, 3'd0);
    send(2'd1, 4'd2, 3'd0);
    send(2'd1, 4'd3, 3'd0);
    check("s123_count", 64'(count), 64'd3);
    check("s123_d0", 64'(displays[0]), 64'h4F);
    check("s123_d2", 64'(displays[2]), 64'h06);
`ifdef CALC_LZB_EN
    check("s123_d3_blank", 64'(displays[3]), 64'h00);
`else
    check("s123_d3", 64'(displays[3]), 64'h3F);
`endif

    // Overflow by nine shifts of 9
    do_reset();
    for (int i = 0; i < 9; i++) send(2'd1, 4'd9, 3'd0);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_d7", 64'(displays[7]), 64'h6F);
    send(2'd2, 4'd0, 3'd0);
    check("bksp_count", 64'(count), 64'd7);
    check("bksp_ovf", 64'(ovf), 64'd1);
`ifdef CALC_LZB_EN
    check("bksp_d7", 64'(displays[7]), 64'h00);
`else
    check("bksp_d7", 64'(displays[7]), 64'h3F);
`endif

    // CLEAR occupancy, with an ignored SHIFT in its first cycle
    send(2'd3, 4'd0, 3'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    lows = 0;
    cmd_valid = 1'b1; cmd_op = 2'd1; dig = 4'd4;
    while (!cmd_ready && lows < 20) begin
      lows++;
      @(posedge clock); #2;
      cmd_valid = 1'b0;
    end
    check("clr_cycles", 64'(lows), 64'd8);
    check("clr_count", 64'(count), 64'd0);
    check("clr_d7", 64'(displays[7]), 64'(exp_digit(7)));
    check("clr_d0", 64'(displays[0]), 64'h3F);

    // WRITE then rejected WRITE
    send(2'd0, 4'd5, 3'd6);
    check("wr_count", 64'(count), 64'd7);
    check("wr_d6", 64'(displays[6]), 64'h6D);
    send(2'd0, 4'd12, 3'd2);
    check("wr_err", 64'(err), 64'd1);
    check("wr_keep_count", 64'(count), 64'd7);
    @(posedge clock); #2;
    check("wr_err_drop", 64'(err), 64'd0);

    // Reset on the 3rd cycle of CLEAR, concurrent with a command
    send(2'd1, 4'd1, 3'd0);
    send(2'd1, 4'd2, 3'd0);
    send(2'd1, 4'd3, 3'd0);
    send(2'd1, 4'd4, 3'd0);
    send(2'd3, 4'd0, 3'd0);
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; dig = 4'd7;
    @(posedge clock); #2;
    reset = 1'b0; cmd_valid = 1'b0;
    check("rclr_ready", 64'(cmd_ready), 64'd1);
    check("rclr_count", 64'(count), 64'd0);
    check("rclr_d7", 64'(displays[7]), 64'(exp_digit(7)));
    check("rclr_d3", 64'(displays[3]), 64'(exp_digit(3)));

    // Randomised traffic, including commands while busy and rare resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      reset = (r == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      cmd_op = (r < 45) ? 2'd1 : (r < 70) ? 2'd0 : (r < 94) ? 2'd2 : 2'd3;
      dig = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      pos = 3'($urandom_range(0, 7));
      @(posedge clock); #2;
    end
    reset = 1'b0; cmd_valid = 1'b0;
    wait_ready();
    @(posedge clock); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
